// File: rtl/ZionDataType.sv
// Shared datapath types for the execute-dispatch slice: operand width,
// register-index width and the shift-operation encoding.
package ZionDataType;

   typedef logic [31:0] CpuType;
   typedef logic [4:0]  RfRs;

   typedef enum logic [1:0] {
      SHIFT_NONE = 2'b00,
      SHIFT_SLL  = 2'b01,
      SHIFT_SRL  = 2'b10,
      SHIFT_SRA  = 2'b11
   } ShiftOp;

   // One-hot shift-enable positions as seen by execute
   localparam int SHEN_SLL = 0;
   localparam int SHEN_SRL = 1;
   localparam int SHEN_SRA = 2;

endpackage

// File: rtl/ex_dispatch_dec.sv
// Combinational decode of a shift instruction into the execute bundle:
// one-hot op enable plus the operand-2 / shift-amount split.
module ex_dispatch_dec
   import ZionDataType::*;
#(
   parameter int XLEN = $bits(CpuType),
   parameter int SHW  = $bits(RfRs)
) (
   input  logic [1:0]      iShiftOp,
   input  logic            iImm,
   input  logic [XLEN-1:0] iRs1Val,
   input  logic [XLEN-1:0] iRs2Val,
   input  logic [SHW-1:0]  iShamt,
   output logic [XLEN-1:0] oS1,
   output logic [XLEN-1:0] oS2,
   output logic [SHW-1:0]  oShamt,
   output logic            oShamtEn,
   output logic [2:0]      oShiftOpEn
);

   ShiftOp w_op;

   assign w_op     = ShiftOp'(iShiftOp);
   assign oS1      = iRs1Val;
   assign oShamtEn = iImm & (w_op != SHIFT_NONE);

   // Execute ORs operand 2 with the shift amount, so only one of them is live
   assign oS2    = oShamtEn ? '0 : iRs2Val;
   assign oShamt = oShamtEn ? iShamt : '0;

   always_comb begin
      oShiftOpEn = 3'b000;
      case (w_op)
         SHIFT_SLL:  oShiftOpEn[SHEN_SLL] = 1'b1;
         SHIFT_SRL:  oShiftOpEn[SHEN_SRL] = 1'b1;
         SHIFT_SRA:  oShiftOpEn[SHEN_SRA] = 1'b1;
         default:    oShiftOpEn = 3'b000;
      endcase
   end

endmodule

// File: rtl/ex_dispatch.sv
// Decode-to-execute dispatch stage: decodes a shift op and holds it in a
// two-entry main/skid buffer so oDeReady can be fully registered.
module ex_dispatch
   import ZionDataType::*;
#(
   parameter int XLEN = $bits(CpuType),
   parameter int SHW  = $bits(RfRs)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            iDeValid,
   output logic            oDeReady,
   input  logic [1:0]      iShiftOp,
   input  logic            iImm,
   input  logic [XLEN-1:0] iRs1Val,
   input  logic [XLEN-1:0] iRs2Val,
   input  logic [SHW-1:0]  iShamt,
   input  logic            iFlush,
   output logic            oExValid,
   input  logic            iExReady,
   output logic [XLEN-1:0] oDeS1,
   output logic [XLEN-1:0] oDeS2,
   output logic [SHW-1:0]  oShamt,
   output logic            oShamtEn,
   output logic [2:0]      oShiftOpEn
);

   localparam int BW = 2*XLEN + SHW + 4;

   logic [XLEN-1:0] w_s1;
   logic [XLEN-1:0] w_s2;
   logic [SHW-1:0]  w_shamt;
   logic            w_shamt_en;
   logic [2:0]      w_op_en;
   logic [BW-1:0]   w_dec_bus;
   logic            w_acc;
   logic            w_main_free;
   logic            w_skid_valid_next;

   logic            r_main_valid;
   logic            r_skid_valid;
   logic            r_de_ready;
   logic [BW-1:0]   r_main_bus;
   logic [BW-1:0]   r_skid_bus;

   ex_dispatch_dec #(.XLEN(XLEN), .SHW(SHW)) u_dec (
      .iShiftOp   (iShiftOp),
      .iImm       (iImm),
      .iRs1Val    (iRs1Val),
      .iRs2Val    (iRs2Val),
      .iShamt     (iShamt),
      .oS1        (w_s1),
      .oS2        (w_s2),
      .oShamt     (w_shamt),
      .oShamtEn   (w_shamt_en),
      .oShiftOpEn (w_op_en)
   );

   assign w_dec_bus   = {w_s1, w_s2, w_shamt, w_shamt_en, w_op_en};
   assign w_acc       = iDeValid & r_de_ready;
   assign w_main_free = ~r_main_valid | iExReady;

   // Skid only stays/becomes occupied if main cannot absorb it this cycle
   assign w_skid_valid_next = w_main_free ? (r_skid_valid & w_acc)
                                          : (r_skid_valid | w_acc);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
         r_de_ready   <= 1'b1;
         r_main_bus   <= '0;
         r_skid_bus   <= '0;
      end else if (iFlush) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
         r_de_ready   <= 1'b1;
      end else begin
         if (w_main_free) begin
            if (r_skid_valid) begin
               r_main_valid <= 1'b1;
               r_main_bus   <= r_skid_bus;
               if (w_acc) r_skid_bus <= w_dec_bus;
            end else begin
               r_main_valid <= w_acc;
               if (w_acc) r_main_bus <= w_dec_bus;
            end
         end else if (w_acc) begin
            r_skid_bus <= w_dec_bus;
         end
         r_skid_valid <= w_skid_valid_next;
         r_de_ready   <= ~w_skid_valid_next;
      end
   end

   assign oDeReady = r_de_ready;
   assign oExValid = r_main_valid;
   assign {oDeS1, oDeS2, oShamt, oShamtEn, oShiftOpEn} = r_main_bus;

endmodule

// File: doc/ex_dispatch.md
EX_DISPATCH -- requirements
Module: ex_dispatch

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand width (CpuType).
REQ-002 SHALL have parameter SHW, default 5: shift-amount width (RfRs).
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port iDeValid, input, 1: decode offers an instruction.
REQ-006 SHALL have port oDeReady, output, 1: dispatch can accept; driven from a register.
REQ-007 SHALL have port iShiftOp, input, 2: 00 none, 01 SLL, 10 SRL, 11 SRA.
REQ-008 SHALL have port iImm, input, 1: immediate-shift form.
REQ-009 SHALL have ports iRs1Val and iRs2Val, input, XLEN each: register operands.
REQ-010 SHALL have port iShamt, input, SHW: immediate shift amount.
REQ-011 SHALL have port iFlush, input, 1: discard all held instructions.
REQ-012 SHALL have port oExValid, output, 1: execute bundle valid.
REQ-013 SHALL have port iExReady, input, 1: execute accepts the bundle.
REQ-014 SHALL have ports oDeS1 (XLEN), oDeS2 (XLEN), oShamt (SHW), oShamtEn (1) and oShiftOpEn (3), output: the ExIfs bundle.

Function
REQ-015 SHALL accept (transfer in) only when iDeValid & oDeReady; SHALL transfer out only when oExValid & iExReady.
REQ-016 SHALL hold a 2-entry buffer, main and skid; oExValid/bundle SHALL come from main only.
REQ-017 SHALL set oShiftOpEn one-hot: bit0 SLL, bit1 SRL, bit2 SRA; 3'b000 for op none.
REQ-018 SHALL set oShamtEn = iImm & (iShiftOp != 00).
REQ-019 SHALL drive oDeS2 = 0 and oShamt = iShamt when oShamtEn=1; otherwise oDeS2 = iRs2Val and oShamt = 0, since execute ORs the two.
REQ-020 SHALL drive oDeS1 = iRs1Val for every accepted instruction.
REQ-021 SHALL have 1-cycle latency: accept at cycle N with buffer empty means oExValid=1 at N+1.
REQ-022 SHALL keep the bundle stable while oExValid & ~iExReady.
REQ-023 SHALL route an accept into skid when main is valid and not leaving this cycle.
REQ-024 SHALL move skid to main on main drain, in the same cycle the drain occurs, with order preserved.
REQ-025 SHALL register oDeReady = ~skid_valid_next, giving a full-throughput stream at iExReady=1.
REQ-026 SHALL handle simultaneous accept and drain with main and skid empty-ish: new entry goes to main, no bubble.
REQ-027 SHALL, when both entries are full, hold oDeReady=0 and ignore iDeValid.
REQ-028 SHALL, on iFlush, clear both valids at the next edge, set oDeReady=1 and drop any same-cycle accept; flush has priority.

Reset
REQ-029 SHALL, when rst_n=0 at the edge, clear main and skid valids, set oExValid=0 and oDeReady=1, and zero all bundle outputs.
REQ-030 SHALL, on reset mid-transfer, lose in-flight instructions with no partial output.

Structure
REQ-031 SHALL place CpuType, RfRs and the ShiftOp enum in ZionDataType; XLEN and SHW SHALL derive from them.
REQ-032 SHALL use one sub-module, ex_dispatch_dec (combinational op-to-bundle decode), instantiated once before the buffer.

Verification
REQ-033 SHALL cover: SLL reg, Rs1=0x1, Rs2=0x4, iExReady=1 -> next cycle oShiftOpEn=001, oDeS2=4, oShamtEn=0.
REQ-034 SHALL cover: SRAI, shamt=31, Rs2=0xFFFF -> oShiftOpEn=100, oShamtEn=1, oDeS2=0, oShamt=31.
REQ-035 SHALL cover: 3 back-to-back accepts with iExReady=0 -> 2 held, oDeReady=0 after 2nd; iExReady=1 then yields them in order, no loss.
REQ-036 SHALL cover: streaming 8 instructions with iExReady=1 -> 8 transfers in 9 cycles, oDeReady constant 1.
REQ-037 SHALL cover: iFlush with both entries full plus iDeValid=1 -> next cycle oExValid=0, oDeReady=1, nothing emitted.
REQ-038 SHALL cover: rst_n=0 for one cycle mid-stream -> all outputs zero and oDeReady=1 at the following edge.
